// File: rtl/bf_resp_checker.sv
// bf_resp_checker: response checker for 3-input boolean-function DUTs.
// Compares each accepted {a,b,c,x} sample against TRUTH_TABLE through a
// two-stage pipeline. It counts vectors and failures, tracks input coverage,
// and reports a done/pass verdict.
// Optional build macro FIRST_FAIL_CAPTURE_EN adds the first-failure capture
// outputs ff_valid, ff_vec and ff_x.
module bf_resp_checker #(
  parameter logic [7:0]  TRUTH_TABLE = 8'hE8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned NUM_VEC     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             x,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [7:0]       coverage
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic             ff_valid,
  output logic [2:0]       ff_vec,
  output logic             ff_x
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q;
  logic [CNT_W-1:0] acc_cnt_q;   // samples accepted at stage 1, drives the NUM_VEC limit
  logic             s1_valid_q;
  logic [2:0]       s1_vec_q;
  logic             s1_x_q;
  logic             s1_exp_q;
  logic [CNT_W-1:0] vec_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [7:0]       coverage_q;
  logic             mismatch_q;

  logic [2:0] in_vec;
  logic       accept;
  logic       limit_hit;
  logic       s1_fail;

  assign in_vec    = {a, b, c};
  assign accept    = (state_q == ST_RUN) && in_valid && !start;
  assign limit_hit = (NUM_VEC != 0) && accept && (sat_inc(acc_cnt_q) == NUM_VEC_C);
  assign s1_fail   = s1_x_q ^ s1_exp_q;

  // Run-control FSM; start overrides every state, including a simultaneous stop.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state and data registers use non-blocking assignments, so every
    // block reads the pre-edge values no matter how the blocks are ordered.
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else if (start) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE:  state_q <= ST_IDLE;
        ST_RUN:   if (stop || limit_hit) state_q <= ST_DRAIN;
        ST_DRAIN: state_q <= ST_DONE;
        ST_DONE:  state_q <= ST_DONE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Stage 1: capture the accepted sample together with its expected output bit.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the capture data registers are reset as well, not only the valid
    // flag, so that no value from an aborted run is left visible after reset.
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_vec_q   <= '0;
      s1_x_q     <= 1'b0;
      s1_exp_q   <= 1'b0;
      acc_cnt_q  <= '0;
    end else if (start) begin
      s1_valid_q <= 1'b0;
      s1_vec_q   <= '0;
      s1_x_q     <= 1'b0;
      s1_exp_q   <= 1'b0;
      acc_cnt_q  <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_vec_q  <= in_vec;
        s1_x_q    <= x;
        s1_exp_q  <= TRUTH_TABLE[in_vec];
        acc_cnt_q <= sat_inc(acc_cnt_q);
      end
    end
  end

  // Stage 2: retire the captured sample into the counters, coverage and mismatch pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt_q  <= '0;
      fail_cnt_q <= '0;
      coverage_q <= '0;
      mismatch_q <= 1'b0;
    end else if (start) begin
      vec_cnt_q  <= '0;
      fail_cnt_q <= '0;
      coverage_q <= '0;
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= s1_valid_q && s1_fail;
      if (s1_valid_q) begin
        vec_cnt_q            <= sat_inc(vec_cnt_q);
        coverage_q[s1_vec_q] <= 1'b1;
        if (s1_fail) fail_cnt_q <= sat_inc(fail_cnt_q);
      end
    end
  end

  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign pass     = done && (fail_cnt_q == '0) && (coverage_q == 8'hFF);
  assign mismatch = mismatch_q;
  assign vec_cnt  = vec_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign coverage = coverage_q;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic       ff_valid_q;
  logic [2:0] ff_vec_q;
  logic       ff_x_q;

  // First-failure capture: latch the first failing sample of a run and hold it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
      ff_x_q     <= 1'b0;
    end else if (start) begin
      ff_valid_q <= 1'b0;
      ff_vec_q   <= '0;
      ff_x_q     <= 1'b0;
    end else if (s1_valid_q && s1_fail && !ff_valid_q) begin
      ff_valid_q <= 1'b1;
      ff_vec_q   <= s1_vec_q;
      ff_x_q     <= s1_x_q;
    end
  end

  assign ff_valid = ff_valid_q;
  assign ff_vec   = ff_vec_q;
  assign ff_x     = ff_x_q;
`endif

endmodule

// File: tb/tb_bf_resp_checker.sv
// Directed testbench for bf_resp_checker (TRUTH_TABLE=8'hE8, NUM_VEC=8, CNT_W=16).
// If FIRST_FAIL_CAPTURE_EN is defined, the first-failure outputs are checked too.
module tb_bf_resp_checker;

  localparam logic [7:0] MAJ_X = 8'hE8;  // majority: x for {a,b,c}=0..7 is 0,0,0,1,0,1,1,1

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        in_valid;
  logic        a;
  logic        b;
  logic        c;
  logic        x;
  logic        busy;
  logic        done;
  logic        pass;
  logic        mismatch;
  logic [15:0] vec_cnt;
  logic [15:0] fail_cnt;
  logic [7:0]  coverage;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic        ff_valid;
  logic [2:0]  ff_vec;
  logic        ff_x;
`endif

  int checks   = 0;
  int failures = 0;
  int pulses;
  int pulse_at;

  bf_resp_checker #(
    .TRUTH_TABLE(8'hE8),
    .CNT_W      (16),
    .NUM_VEC    (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .in_valid(in_valid),
    .a       (a),
    .b       (b),
    .c       (c),
    .x       (x),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .mismatch(mismatch),
    .vec_cnt (vec_cnt),
    .fail_cnt(fail_cnt),
    .coverage(coverage)
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    .ff_valid(ff_valid),
    .ff_vec  (ff_vec),
    .ff_x    (ff_x)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input int v, input logic xv);
    logic [2:0] abc;
    abc = v[2:0];
    in_valid = 1'b1;
    {a, b, c} = abc;
    x = xv;
  endtask

  // Feed samples 000..111 with x taken from xs, then one idle cycle.
  // Mismatch pulses are counted; pulse_at is the tick index of the last one.
  task automatic run_vectors(input logic [7:0] xs, output int np, output int at);
    np = 0;
    at = -1;
    for (int t = 0; t < 9; t++) begin
      if (t < 8) drive(t, xs[t]);
      else in_valid = 1'b0;
      tick();
      if (mismatch === 1'b1) begin
        np++;
        at = t;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    a = 1'b0; b = 1'b0; c = 1'b0; x = 1'b0;

    // 1: asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_busy", busy, 0);
    check("rst_async_done", done, 0);
    check("rst_async_vec",  vec_cnt, 0);
    check("rst_async_cov",  coverage, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_rel_busy", busy, 0);
    check("rst_rel_done", done, 0);
    check("rst_rel_pass", pass, 0);

    // 2: full correct run
    pulse_start();
    check("t2_busy_run", busy, 1);
    run_vectors(MAJ_X, pulses, pulse_at);
    check("t2_done",     done, 1);
    check("t2_busy",     busy, 0);
    check("t2_vec",      vec_cnt, 8);
    check("t2_fail",     fail_cnt, 0);
    check("t2_cov",      coverage, 8'hFF);
    check("t2_pass",     pass, 1);
    check("t2_pulses",   pulses, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    check("t2_ff_valid", ff_valid, 0);
`endif

    // 3: sample 101 answered with x=0; it is captured at tick 5 and flagged at tick 6
    pulse_start();
    check("t3_cleared_vec", vec_cnt, 0);
    run_vectors(8'hC8, pulses, pulse_at);
    check("t3_pulses",   pulses, 1);
    check("t3_pulse_at", pulse_at, 6);
    check("t3_fail",     fail_cnt, 1);
    check("t3_vec",      vec_cnt, 8);
    check("t3_done",     done, 1);
    check("t3_pass",     pass, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    check("t3_ff_valid", ff_valid, 1);
    check("t3_ff_vec",   ff_vec, 3'b101);
    check("t3_ff_x",     ff_x, 0);
`endif

    // 4: early stop arriving with the 4th sample
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      drive(i, MAJ_X[i]);
      tick();
    end
    drive(3, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    in_valid = 1'b0;
    check("t4_drain_busy", busy, 1);
    check("t4_drain_done", done, 0);
    check("t4_drain_vec",  vec_cnt, 3);
    tick();
    check("t4_done", done, 1);
    check("t4_vec",  vec_cnt, 4);
    check("t4_cov",  coverage, 8'h0F);
    check("t4_fail", fail_cnt, 0);
    check("t4_pass", pass, 0);

    // 5: reset in the middle of a run, then a clean run
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      drive(i, MAJ_X[i]);
      tick();
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_vec",  vec_cnt, 0);
    check("t5_rst_cov",  coverage, 0);
    check("t5_rst_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("t5_idle_busy", busy, 0);
    pulse_start();
    run_vectors(MAJ_X, pulses, pulse_at);
    check("t5_vec",  vec_cnt, 8);
    check("t5_pass", pass, 1);

    // 6a: in_valid while DONE is ignored, including a wrong x
    drive(5, 1'b0);
    repeat (3) tick();
    in_valid = 1'b0;
    check("t6_done_vec",  vec_cnt, 8);
    check("t6_done_fail", fail_cnt, 0);
    check("t6_done_pass", pass, 1);

    // 6b: start together with in_valid in RUN drops the sample
    pulse_start();
    drive(3, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    check("t6_drop_vec",  vec_cnt, 0);
    check("t6_drop_cov",  coverage, 0);
    check("t6_drop_busy", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("t6_stop_done", done, 1);
    check("t6_stop_pass", pass, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
